// File: rtl/bcast_session_sequencer.sv
// Metadata scheduler for the top-k broadcast path: replays a software-written
// session-ID table, one word per worker, for every accepted payload block.
module bcast_session_sequencer #(
  parameter int MAX_WORKERS = 64,
  parameter int IDX_W       = 6,
  parameter int SID_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [SID_W-1:0] cfg_sid,
  output logic             cfg_err,
  input  logic [29:0]      num_workers,
  input  logic             enable,
  input  logic             blk_req_TVALID,
  output logic             blk_req_TREADY,
  output logic [SID_W-1:0] metadata_tx_TDATA,
  output logic             metadata_tx_TVALID,
  input  logic             metadata_tx_TREADY,
  output logic             busy,
  output logic             nw_invalid,
  output logic [31:0]      blk_done_count
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic [29:0]  MAX_NW  = 30'(MAX_WORKERS);
  localparam logic [IDX_W:0] NW_ONE = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  state_t           state_r;
  logic [SID_W-1:0] table_r [MAX_WORKERS];
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W:0]   nw_r;
  logic [31:0]      blk_done_count_r;
  logic             cfg_err_r;

  logic             nw_invalid_s;
  logic             req_ready_s;
  logic             req_hs_s;
  logic             md_hs_s;
  logic             last_word_s;

  assign nw_invalid_s = (num_workers == 30'd0) || (num_workers > MAX_NW);
  assign req_ready_s  = (state_r == IDLE) && enable && !nw_invalid_s;
  assign req_hs_s     = blk_req_TVALID && req_ready_s;
  assign md_hs_s      = (state_r == EMIT) && metadata_tx_TREADY;
  // nw_r is at least 1 once latched, so nw_r - 1 never underflows in EMIT
  assign last_word_s  = ({1'b0, idx_r} == (nw_r - NW_ONE));

  // Block FSM, word index, completion counter, table storage and write-drop flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= IDLE;
      idx_r            <= '0;
      nw_r             <= '0;
      blk_done_count_r <= 32'd0;
      cfg_err_r        <= 1'b0;
      for (int i = 0; i < MAX_WORKERS; i++) begin
        table_r[i] <= '0;
      end
    end else begin
      cfg_err_r <= cfg_we && (state_r == EMIT);
      case (state_r)
        IDLE: begin
          if (cfg_we) begin
            table_r[cfg_addr] <= cfg_sid;
          end
          if (req_hs_s) begin
            nw_r    <= num_workers[IDX_W:0];
            idx_r   <= '0;
            state_r <= EMIT;
          end
        end
        EMIT: begin
          if (md_hs_s) begin
            if (last_word_s) begin
              state_r          <= IDLE;
              blk_done_count_r <= blk_done_count_r + 32'd1;
            end else begin
              idx_r <= idx_r + IDX_ONE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign blk_req_TREADY     = req_ready_s;
  assign metadata_tx_TVALID = (state_r == EMIT);
  assign metadata_tx_TDATA  = table_r[idx_r];
  assign busy               = (state_r == EMIT);
  assign nw_invalid         = nw_invalid_s;
  assign blk_done_count     = blk_done_count_r;
  assign cfg_err            = cfg_err_r;

endmodule
